// File: rtl/sram_ctrl.sv
// Pipelined Wishbone slave driving an async SRAM.
// One access in flight; fixed wait states.
module sram_ctrl #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 32,
  parameter int WAIT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [DWIDTH-1:0] dat_i,
  output logic [DWIDTH-1:0] dat_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic [AWIDTH-1:0] sram_adr_o,
  output logic [DWIDTH-1:0] sram_dat_o,
  output logic              sram_dat_oe,
  input  logic [DWIDTH-1:0] sram_dat_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       we_q;
  logic       accept;
  logic       last;

  assign stall_o = (state != IDLE);
  assign accept  = cyc_i & stb_i & ~stall_o;
  assign last    = (cnt == 4'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      ack_o       <= 1'b0;
      dat_o       <= '0;
      sram_adr_o  <= '0;
      sram_dat_o  <= '0;
      sram_dat_oe <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 4'hF;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= ACCESS;
            cnt         <= WAIT_C;
            we_q        <= we_i;
            sram_adr_o  <= adr_i;
            sram_dat_o  <= dat_i;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= we_i;
            sram_we_n   <= ~we_i;
            sram_dat_oe <= we_i;
            sram_be_n   <= we_i ? ~sel_i : 4'h0;
          end
        end
        ACCESS: begin
          if (last) begin
            ack_o     <= cyc_i;
            sram_ce_n <= 1'b1;
            if (we_q) begin
              // data, address and lanes stay put for hold time
              state     <= RECOVER;
              sram_we_n <= 1'b1;
            end else begin
              state     <= IDLE;
              dat_o     <= sram_dat_i;
              sram_oe_n <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          state       <= IDLE;
          sram_dat_oe <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          sram_ce_n   <= 1'b1;
          sram_oe_n   <= 1'b1;
          sram_we_n   <= 1'b1;
          sram_dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
